fir_out_quant: RTL and testbench
================================

FIR_OUT_QUANT -- requirements
Module: fir_out_quant

Interface
REQ-001 Parameter: IN_W, 48, width of the accumulator word from the last FIR tap.
REQ-002 Parameter: OUT_W, 24, width of the output sample sent to the I2S transmitter.
REQ-003 Parameter: SHIFT, 17, number of fractional bits removed (Q1.17 coefficients); range 1..IN_W-OUT_W.
REQ-004 Parameter: DEPTH, 4, output FIFO depth; power of two, at least 2.
REQ-005 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-006 Port: rst  in  1  reset, asynchronous and active-high.
REQ-007 Port: in_valid  in  1  in_data holds a new filter result this cycle.
REQ-008 Port: in_data  in  IN_W  signed two's-complement accumulator word (p).
REQ-009 Port: out_data  out  OUT_W  signed sample at the FIFO head.
REQ-010 Port: out_valid  out  1  out_data is valid.
REQ-011 Port: out_ready  in  1  consumer accepts out_data this cycle.
REQ-012 Port: level  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 Port: sat_flag  out  1  sticky: at least one sample was saturated.
REQ-014 Port: drop_flag  out  1  sticky: at least one sample was lost because the FIFO was full.
REQ-015 Port: flag_clr  in  1  synchronous clear of sat_flag and drop_flag.

Function
REQ-016 Stage 1 SHALL register in_data sign-extended to IN_W+1 bits plus 2^(SHIFT-1), together with a valid bit (round half up).
REQ-017 Stage 2 SHALL arithmetic-shift the stage-1 sum right by SHIFT, clamp it to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and register the result, a valid bit and a saturation bit.
REQ-018 A word sampled with in_valid at edge k SHALL be written into the FIFO at edge k+2; out_valid SHALL be high after edge k+2 if the FIFO was empty.
REQ-019 The pipeline SHALL accept one word per clock with no stall; in_valid has no backpressure.
REQ-020 The FIFO SHALL be first-word-fall-through: out_valid = (level != 0), and out_data = head entry, stable while out_valid && !out_ready.
REQ-021 A pop SHALL occur on an edge where out_valid && out_ready; out_ready while empty SHALL have no effect.
REQ-022 A simultaneous push and pop SHALL leave level unchanged and keep order, including when full.
REQ-023 A push into a full FIFO with no simultaneous pop SHALL discard the new word, leave the contents unchanged and set drop_flag.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-025 sat_flag SHALL set at the edge where a saturated word leaves stage 2, including a word that is then dropped.
REQ-026 flag_clr SHALL clear both flags; when flag_clr and a new set event occur on the same edge, the set SHALL win.
REQ-027 Pipeline valid bits SHALL be cleared whenever in_valid is low; data registers need not be.

Reset
REQ-028 rst high SHALL immediately clear the stage valid bits, the FIFO pointers, level, sat_flag and drop_flag, and force out_valid=0 and out_data=0, regardless of clk.
REQ-029 A word in flight when rst asserts SHALL be lost; the first in_valid sampled after rst falls follows REQ-018 exactly.

Verification (SHIFT=17, OUT_W=24, DEPTH=4)
REQ-030 Rounding: in_data=131072, 65536, 65535, -65536, -65537 with out_ready=1 -> out_data=1, 1, 0, 0, -1, each two clocks after input, sat_flag=0.
REQ-031 Saturation: in_data=2^47-1 then -2^47 -> out_data=0x7FFFFF then 0x800000, sat_flag=1; flag_clr pulse -> sat_flag=0.
REQ-032 Full/drop: out_ready=0, six consecutive in_valid words 1..6 (scaled by 2^17) -> level=4, drop_flag=1; then out_ready=1 -> out_data 1,2,3,4 in order, then out_valid=0.
REQ-033 Full with simultaneous pop: FIFO full and out_ready=1 on every cycle with a continuous input stream -> no drop, level stays 4, order preserved.
REQ-034 Reset mid-operation: rst asserted asynchronously between edges with level=3 -> out_valid=0, level=0, flags=0 before the next edge; the next input appears at output after two edges.

Source files
------------

// File: rtl/fir_out_quant_if.sv
// fir_out_quant_if: input stream (in_valid/in_data) and FWFT output stream
// (out_data/out_valid/out_ready) of the FIR output quantiser.
//   master: producer/consumer side (drives in_*, out_ready)
//   slave : quantiser side (drives out_data, out_valid)
interface fir_out_quant_if #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 24
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  in_data;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (output in_valid, in_data, out_ready, input out_data, out_valid);
    modport slave  (input in_valid, in_data, out_ready, output out_data, out_valid);
endinterface

// File: rtl/fir_out_quant.sv
// fir_out_quant: rounds (half up) and saturates a FIR accumulator word to an
// output sample, then buffers it in a first-word-fall-through FIFO.
//   clk, rst   : clock, asynchronous active-high reset
//   s          : stream interface (in_valid/in_data in, out_data/out_valid/out_ready out)
//   level      : FIFO occupancy 0..DEPTH
//   sat_flag   : sticky, a sample was clamped
//   drop_flag  : sticky, a sample was discarded because the FIFO was full
//   flag_clr   : synchronous clear of both sticky flags (a same-edge set wins)
module fir_out_quant #(
    parameter int IN_W  = 48,
    parameter int OUT_W = 24,
    parameter int SHIFT = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    fir_out_quant_if.slave         s,
    output logic [$clog2(DEPTH):0] level,
    output logic                   sat_flag,
    output logic                   drop_flag,
    input  logic                   flag_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [IN_W:0]    HALF = (IN_W+1)'(1) << (SHIFT - 1);
    localparam logic [OUT_W-1:0] MAXV = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MINV = {1'b1, {(OUT_W-1){1'b0}}};

    logic                   s1_v, s2_v, s2_sat;
    logic signed [IN_W:0]   s1_sum, shr;
    logic [OUT_W-1:0]       s2_data;
    logic [OUT_W-1:0]       mem [DEPTH];
    logic [AW-1:0]          wp, rp;
    logic                   fits, full, pop, wr_en, drop;

    assign shr = s1_sum >>> SHIFT;
    // The shifted value fits in OUT_W bits only if all bits above the output
    // sign bit are copies of it.
    assign fits  = (&shr[IN_W:OUT_W-1]) | ~(|shr[IN_W:OUT_W-1]);
    assign full  = level == LW'(DEPTH);
    assign pop   = s.out_valid && s.out_ready;
    assign wr_en = s2_v && (!full || pop);
    assign drop  = s2_v && full && !pop;

    assign s.out_valid = level != '0;
    assign s.out_data  = s.out_valid ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        s1_sum  <= {s.in_data[IN_W-1], s.in_data} + HALF;
        s2_data <= fits ? shr[OUT_W-1:0] : (shr[IN_W] ? MINV : MAXV);
        s2_sat  <= !fits;
        if (wr_en)
            mem[wp] <= s2_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v      <= 1'b0;
            s2_v      <= 1'b0;
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            s1_v      <= s.in_valid;
            s2_v      <= s1_v;
            wp        <= wp + AW'(wr_en);
            rp        <= rp + AW'(pop);
            level     <= level + LW'(wr_en) - LW'(pop);
            sat_flag  <= (sat_flag && !flag_clr) || (s2_v && s2_sat);
            drop_flag <= (drop_flag && !flag_clr) || drop;
        end
    end
endmodule

// File: tb/tb_fir_out_quant.sv
// tb_fir_out_quant: directed self-checking bench for fir_out_quant.
module tb_fir_out_quant;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flag_clr = 1'b0;
    logic [2:0] level;
    logic       sat_flag, drop_flag;
    int         errors = 0;
    int         checks = 0;
    longint     nxt;

    fir_out_quant_if #(.IN_W(48), .OUT_W(24)) bus ();

    fir_out_quant #(.IN_W(48), .OUT_W(24), .SHIFT(17), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s(bus.slave), .level(level),
        .sat_flag(sat_flag), .drop_flag(drop_flag), .flag_clr(flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated word with out_ready=1: invisible after one edge, visible
    // after two, popped on the third.
    task automatic send1(input longint v, input longint e, input string tag);
        bus.in_valid = 1'b1;
        bus.in_data  = 48'(v);
        step();
        bus.in_valid = 1'b0;
        step();
        chk({tag, "_lat"}, longint'(bus.out_valid), 0);
        step();
        chk({tag, "_vld"}, longint'(bus.out_valid), 1);
        chk({tag, "_dat"}, longint'(bus.out_data), e);
        step();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        chk("rst_vld", longint'(bus.out_valid), 0);
        chk("rst_dat", longint'(bus.out_data), 0);
        chk("rst_lvl", longint'(level), 0);
        chk("rst_sat", longint'(sat_flag), 0);
        chk("rst_drop", longint'(drop_flag), 0);
        rst = 1'b0;
        step();

        send1(131072, 1, "rnd0");
        send1(65536, 1, "rnd1");
        send1(65535, 0, "rnd2");
        send1(-65536, 0, "rnd3");
        send1(-65537, -1, "rnd4");
        chk("rnd_sat", longint'(sat_flag), 0);
        chk("rnd_lvl", longint'(level), 0);

        send1(64'sh7FFF_FFFF_FFFF, 8388607, "satp");
        chk("satp_flag", longint'(sat_flag), 1);
        send1(-64'sh8000_0000_0000, -8388608, "satn");
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("sat_clr", longint'(sat_flag), 0);

        // flag_clr on the very edge the saturated word is pushed: set wins
        bus.in_valid = 1'b1;
        bus.in_data  = 48'(64'sh7FFF_FFFF_FFFF);
        step();
        bus.in_valid = 1'b0;
        step();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("set_wins", longint'(sat_flag), 1);
        chk("set_wins_dat", longint'(bus.out_data), 8388607);
        step();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("sat_clr2", longint'(sat_flag), 0);

        // Full/drop: six words into a four-deep FIFO with no consumer
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 48'(longint'(i) << 17);
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        chk("full_lvl", longint'(level), 4);
        chk("full_drop", longint'(drop_flag), 1);
        chk("full_sat", longint'(sat_flag), 0);
        step();
        chk("hold_dat", longint'(bus.out_data), 1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_dat", longint'(bus.out_data), longint'(i));
            step();
        end
        chk("drain_vld", longint'(bus.out_valid), 0);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("drop_clr", longint'(drop_flag), 0);

        // Full with simultaneous push and pop on every edge
        nxt = 1;
        for (int c = 1; c <= 18; c++) begin
            bus.in_valid  = c <= 12;
            bus.in_data   = 48'(longint'(c) << 17);
            bus.out_ready = c >= 7;
            if (bus.out_ready && bus.out_valid) begin
                chk("pp_ord", longint'(bus.out_data), nxt);
                nxt++;
            end
            step();
            if (c >= 6 && c <= 14)
                chk("pp_lvl", longint'(level), 4);
        end
        bus.in_valid = 1'b0;
        chk("pp_count", nxt, 13);
        chk("pp_drop", longint'(drop_flag), 0);
        chk("pp_empty", longint'(bus.out_valid), 0);

        // Asynchronous reset with three words buffered and sat_flag set
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 48'(64'sh7FFF_FFFF_FFFF);
        step();
        bus.in_data = 48'(longint'(2) << 17);
        step();
        bus.in_data = 48'(longint'(3) << 17);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk("pre_lvl", longint'(level), 3);
        chk("pre_sat", longint'(sat_flag), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_vld", longint'(bus.out_valid), 0);
        chk("ar_dat", longint'(bus.out_data), 0);
        chk("ar_lvl", longint'(level), 0);
        chk("ar_sat", longint'(sat_flag), 0);
        chk("ar_drop", longint'(drop_flag), 0);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        step();
        send1(longint'(7) << 17, 7, "post");
        chk("post_lvl", longint'(level), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
